// File: rtl/hour_counter_24.sv
// -----------------------------------------------------------------------------
// hour_counter_24
//
// Hour stage of the digital-clock counter chain. It counts the carry pulses of
// the minute-tens mod-6 stage and holds the hour as two BCD digits. In the
// default 24-hour build the sequence is 00..23, and a one-cycle day carry is
// emitted on the 23 -> 00 step.
//
// Set-time mode lets the user step this stage with set_inc. In that mode no
// carry is propagated, and carry_in events are discarded.
//
// Optional feature (compile-time macro HOUR_12_MODE_EN):
//   defined   : 12-hour sequence 12,01..11 with a pm flag. pm toggles on the
//               11 -> 12 step. The day carry fires on the 11 PM -> 12 AM step.
//   undefined : 24-hour sequence, and pm stays 0.
//
// Parameters
//   RESET_HOUR : hour loaded on reset, decimal 0..23. Out-of-range values
//                load 0.
//   EDGE_DET   : 1 = step on the rising edge of carry_in / set_inc,
//                0 = step on every cycle that the input is high.
//
// Ports
//   clkmain   in  1  clock, all state changes on the rising edge
//   clear_n   in  1  synchronous active-low reset, overrides all inputs
//   carry_in  in  1  count enable from the minute-tens stage
//   set_time  in  1  1 = this stage is being set
//   set_inc   in  1  step request while set_time = 1
//   hr_tens   out 2  BCD tens digit
//   hr_units  out 4  BCD units digit
//   pm        out 1  PM flag (12-hour build only, otherwise 0)
//   carry_out out 1  one-cycle day carry
//
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module hour_counter_24 #(
  parameter int RESET_HOUR = 0,
  parameter bit EDGE_DET   = 1'b1
) (
  input  logic       clkmain,
  input  logic       clear_n,
  input  logic       carry_in,
  input  logic       set_time,
  input  logic       set_inc,
  output logic [1:0] hr_tens,
  output logic [3:0] hr_units,
  output logic       pm,
  output logic       carry_out
);

  // Result of advancing the hour by one step.
  typedef struct packed {
    logic [1:0] tens;
    logic [3:0] units;
    logic       wrap;     // step is the end-of-day rollover
    logic       pm_flip;  // step crosses 11 -> 12 (12-hour build)
  } step_t;

  // An out-of-range reset hour is treated as hour 0.
  localparam int RST_H24_C = ((RESET_HOUR >= 0) && (RESET_HOUR <= 23)) ? RESET_HOUR : 0;

`ifdef HOUR_12_MODE_EN
  // 24h -> 12h mapping: 0 -> 12 AM, 12 -> 12 PM, 13 -> 01 PM.
  localparam int   RST_DISP_C = ((RST_H24_C % 12) == 0) ? 12 : (RST_H24_C % 12);
  localparam logic RST_PM_C   = (RST_H24_C >= 12) ? 1'b1 : 1'b0;
`else
  localparam int   RST_DISP_C = RST_H24_C;
  localparam logic RST_PM_C   = 1'b0;
`endif

  localparam logic [1:0] RST_TENS_C  = 2'(RST_DISP_C / 10);
  localparam logic [3:0] RST_UNITS_C = 4'(RST_DISP_C % 10);

`ifdef HOUR_12_MODE_EN
  // Legal 12-hour display codes are 01..09, 10, 11 and 12.
  function automatic logic is_legal_12(input logic [1:0] t, input logic [3:0] u);
    return ((t == 2'd0) && (u >= 4'd1) && (u <= 4'd9)) ||
           ((t == 2'd1) && (u <= 4'd2));
  endfunction

  // One 12-hour step. An illegal code recovers to 12.
  // The day rollover is the 11 PM -> 12 AM step.
  function automatic step_t advance_12(input logic [1:0] t, input logic [3:0] u,
                                       input logic pm_now);
    step_t r;
    r = '0;
    if (!is_legal_12(t, u)) begin
      r.tens  = 2'd1;
      r.units = 4'd2;
    end else if ((t == 2'd1) && (u == 4'd2)) begin
      r.tens  = 2'd0;
      r.units = 4'd1;
    end else if ((t == 2'd1) && (u == 4'd1)) begin
      r.tens    = 2'd1;
      r.units   = 4'd2;
      r.pm_flip = 1'b1;
      r.wrap    = pm_now;
    end else if (u == 4'd9) begin
      r.tens  = t + 2'd1;
      r.units = 4'd0;
    end else begin
      r.tens  = t;
      r.units = u + 4'd1;
    end
    return r;
  endfunction
`else
  // Legal 24-hour codes: units 0..9, and units at most 3 when tens is 2.
  function automatic logic is_legal_24(input logic [1:0] t, input logic [3:0] u);
    return (u <= 4'd9) && ((t < 2'd2) || ((t == 2'd2) && (u <= 4'd3)));
  endfunction

  // One 24-hour step. An illegal code recovers to 00 without a day carry.
  function automatic step_t advance_24(input logic [1:0] t, input logic [3:0] u);
    step_t r;
    r = '0;
    if (!is_legal_24(t, u)) begin
      r.tens  = 2'd0;
      r.units = 4'd0;
    end else if ((t == 2'd2) && (u == 4'd3)) begin
      r.tens  = 2'd0;
      r.units = 4'd0;
      r.wrap  = 1'b1;
    end else if (u == 4'd9) begin
      r.tens  = t + 2'd1;
      r.units = 4'd0;
    end else begin
      r.tens  = t;
      r.units = u + 4'd1;
    end
    return r;
  endfunction
`endif

  logic [1:0] tens_r;
  logic [3:0] units_r;
  logic       pm_r;
  logic       carry_r;
  logic       carry_hist_r;
  logic       inc_hist_r;

  logic       carry_evt_s;
  logic       inc_evt_s;
  logic       step_s;
  step_t      adv_s;

  // Step-event detection, and selection of the event source from the mode.
  always_comb begin
    carry_evt_s = 1'b0;
    inc_evt_s   = 1'b0;
    step_s      = 1'b0;
    if (EDGE_DET) begin
      carry_evt_s = carry_in & ~carry_hist_r;
      inc_evt_s   = set_inc & ~inc_hist_r;
    end else begin
      carry_evt_s = carry_in;
      inc_evt_s   = set_inc;
    end
    // Only one source is active per cycle, so the other source's events are dropped.
    if (set_time) begin
      step_s = inc_evt_s;
    end else begin
      step_s = carry_evt_s;
    end
  end

  // Next hour value if a step happens this cycle.
  always_comb begin
    adv_s = '0;
`ifdef HOUR_12_MODE_EN
    adv_s = advance_12(tens_r, units_r, pm_r);
`else
    adv_s = advance_24(tens_r, units_r);
`endif
  end

  // State registers: digits, pm flag, day carry and edge-detect history.
  always_ff @(posedge clkmain) begin
    if (!clear_n) begin
      tens_r       <= RST_TENS_C;
      units_r      <= RST_UNITS_C;
      pm_r         <= RST_PM_C;
      carry_r      <= 1'b0;
      // Preloading 1 prevents an input that is held high through reset from
      // looking like a rising edge.
      carry_hist_r <= 1'b1;
      inc_hist_r   <= 1'b1;
    end else begin
      carry_hist_r <= carry_in;
      inc_hist_r   <= set_inc;
      if (step_s) begin
        tens_r  <= adv_s.tens;
        units_r <= adv_s.units;
        pm_r    <= pm_r ^ adv_s.pm_flip;
        carry_r <= adv_s.wrap & ~set_time;
      end else begin
        tens_r  <= tens_r;
        units_r <= units_r;
        pm_r    <= pm_r;
        carry_r <= 1'b0;
      end
    end
  end

  assign hr_tens   = tens_r;
  assign hr_units  = units_r;
  assign pm        = pm_r;
  assign carry_out = carry_r;

endmodule

// File: tb/tb_hour_counter_24.sv
module tb_hour_counter_24;

  logic clkmain = 1'b0;
  always #5 clkmain = ~clkmain;

  logic clear_n;

  // dut_a: default parameters (RESET_HOUR=0, EDGE_DET=1).
  logic       a_carry_in, a_set_time, a_set_inc;
  logic [1:0] a_tens;
  logic [3:0] a_units;
  logic       a_pm, a_carry;

  // dut_b: level-sensitive stepping, reset hour 19.
  logic       b_carry_in;
  logic       b_zero;
  logic [1:0] b_tens;
  logic [3:0] b_units;
  logic       b_pm, b_carry;

  // dut_c: reset hour 23; dut_d: out-of-range reset hour. They share inputs.
  logic       c_carry_in;
  logic [1:0] c_tens, d_tens;
  logic [3:0] c_units, d_units;
  logic       c_pm, c_carry, d_pm, d_carry;

  hour_counter_24 dut_a (
    .clkmain(clkmain), .clear_n(clear_n), .carry_in(a_carry_in),
    .set_time(a_set_time), .set_inc(a_set_inc), .hr_tens(a_tens),
    .hr_units(a_units), .pm(a_pm), .carry_out(a_carry)
  );

  hour_counter_24 #(.RESET_HOUR(19), .EDGE_DET(1'b0)) dut_b (
    .clkmain(clkmain), .clear_n(clear_n), .carry_in(b_carry_in),
    .set_time(b_zero), .set_inc(b_zero), .hr_tens(b_tens),
    .hr_units(b_units), .pm(b_pm), .carry_out(b_carry)
  );

  hour_counter_24 #(.RESET_HOUR(23)) dut_c (
    .clkmain(clkmain), .clear_n(clear_n), .carry_in(c_carry_in),
    .set_time(b_zero), .set_inc(b_zero), .hr_tens(c_tens),
    .hr_units(c_units), .pm(c_pm), .carry_out(c_carry)
  );

  hour_counter_24 #(.RESET_HOUR(30)) dut_d (
    .clkmain(clkmain), .clear_n(clear_n), .carry_in(c_carry_in),
    .set_time(b_zero), .set_inc(b_zero), .hr_tens(d_tens),
    .hr_units(d_units), .pm(d_pm), .carry_out(d_carry)
  );

  typedef struct {
    logic carry_in;
    logic set_time;
    logic set_inc;
    int   exp_hour;
    logic exp_carry;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(input logic ci, input logic st, input logic si,
                              input int hour, input logic co);
    vec_t v;
    v.carry_in  = ci;
    v.set_time  = st;
    v.set_inc   = si;
    v.exp_hour  = hour;
    v.exp_carry = co;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_dut(input string name, input logic [1:0] t, input logic [3:0] u,
                           input logic p, input logic c, input int hour, input logic co);
    check({name, ".tens"}, int'(t), hour / 10);
    check({name, ".units"}, int'(u), hour % 10);
    check({name, ".pm"}, int'(p), 0);
    check({name, ".carry"}, int'(c), int'(co));
  endtask

  task automatic tick();
    @(posedge clkmain);
    #1;
  endtask

  initial begin
    clear_n    = 1'b0;
    a_carry_in = 1'b0;
    a_set_time = 1'b0;
    a_set_inc  = 1'b0;
    b_carry_in = 1'b0;
    b_zero     = 1'b0;
    c_carry_in = 1'b0;
    tick();
    tick();

    // Reset values, including the out-of-range reset hour.
    check_dut("rst_a", a_tens, a_units, a_pm, a_carry, 0, 1'b0);
    check_dut("rst_b", b_tens, b_units, b_pm, b_carry, 19, 1'b0);
    check_dut("rst_c", c_tens, c_units, c_pm, c_carry, 23, 1'b0);
    check_dut("rst_d", d_tens, d_units, d_pm, d_carry, 0, 1'b0);
    clear_n = 1'b1;

    // Full day of carry_in pulses: 01..23, 00, with the day carry on the 24th.
    add(1'b0, 1'b0, 1'b0, 0, 1'b0);
    for (int i = 1; i <= 24; i++) begin
      add(1'b1, 1'b0, 1'b0, i % 24, (i == 24) ? 1'b1 : 1'b0);
      add(1'b0, 1'b0, 1'b0, i % 24, 1'b0);
    end
    // Set mode: 30 set_inc pulses from 00 reach 06 with no carry.
    add(1'b0, 1'b1, 1'b0, 0, 1'b0);
    for (int i = 1; i <= 30; i++) begin
      add(1'b0, 1'b1, 1'b1, i % 24, 1'b0);
      add(1'b0, 1'b1, 1'b0, i % 24, 1'b0);
    end
    // Set mode drops carry_in pulses.
    add(1'b1, 1'b1, 1'b0, 6, 1'b0);
    add(1'b0, 1'b1, 1'b0, 6, 1'b0);
    add(1'b1, 1'b1, 1'b0, 6, 1'b0);
    add(1'b0, 1'b1, 1'b0, 6, 1'b0);
    add(1'b0, 1'b0, 1'b0, 6, 1'b0);
    // A carry_in event that coincides with set_time rising is lost.
    add(1'b1, 1'b1, 1'b0, 6, 1'b0);
    add(1'b0, 1'b0, 1'b0, 6, 1'b0);
    add(1'b1, 1'b0, 1'b0, 7, 1'b0);
    add(1'b0, 1'b0, 1'b0, 7, 1'b0);
    // In normal mode set_inc is ignored.
    add(1'b0, 1'b0, 1'b1, 7, 1'b0);
    add(1'b0, 1'b0, 1'b0, 7, 1'b0);
    // With edge detection, carry_in held high for 10 cycles gives one step.
    for (int i = 0; i < 10; i++) add(1'b1, 1'b0, 1'b0, 8, 1'b0);
    add(1'b0, 1'b0, 1'b0, 8, 1'b0);
    // Count up to 17 for the mid-count reset.
    for (int h = 9; h <= 17; h++) begin
      add(1'b1, 1'b0, 1'b0, h, 1'b0);
      add(1'b0, 1'b0, 1'b0, h, 1'b0);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      a_carry_in = vecs[i].carry_in;
      a_set_time = vecs[i].set_time;
      a_set_inc  = vecs[i].set_inc;
      tick();
      check_dut($sformatf("vec%0d", i), a_tens, a_units, a_pm, a_carry,
                vecs[i].exp_hour, vecs[i].exp_carry);
    end

    // Reset at 17 with carry_in high: reset wins, and there is no step until carry_in re-rises.
    a_set_time = 1'b0;
    a_set_inc  = 1'b0;
    clear_n    = 1'b0;
    a_carry_in = 1'b1;
    tick();
    check_dut("midrst", a_tens, a_units, a_pm, a_carry, 0, 1'b0);
    clear_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_dut($sformatf("held%0d", i), a_tens, a_units, a_pm, a_carry, 0, 1'b0);
    end
    a_carry_in = 1'b0;
    tick();
    check_dut("fall", a_tens, a_units, a_pm, a_carry, 0, 1'b0);
    a_carry_in = 1'b1;
    tick();
    check_dut("rerise", a_tens, a_units, a_pm, a_carry, 1, 1'b0);
    a_carry_in = 1'b0;

    // Level mode from 19: 10 cycles high gives 10 steps, wrapping through 00 with one carry.
    b_carry_in = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check_dut($sformatf("lvl%0d", k), b_tens, b_units, b_pm, b_carry,
                (19 + k) % 24, (((19 + k) % 24) == 0) ? 1'b1 : 1'b0);
    end
    b_carry_in = 1'b0;
    tick();
    check_dut("lvl_end", b_tens, b_units, b_pm, b_carry, 5, 1'b0);

    // From 23, one pulse gives 00 plus a one-cycle day carry.
    c_carry_in = 1'b1;
    tick();
    check_dut("wrap23", c_tens, c_units, c_pm, c_carry, 0, 1'b1);
    c_carry_in = 1'b0;
    tick();
    check_dut("wrap23_after", c_tens, c_units, c_pm, c_carry, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
